hyperbus_wb_bridge: RTL and testbench

// Wishbone B4 classic 32-bit slave that drives the user side of hyperbus_fifo
// (rrq/wrq, adr, tx data/mask, rx data). Sits directly upstream of hyperbus_fifo
// so a CPU or SoC interconnect can reach HyperRAM. Writes are posted; reads

---
 rtl/hyperbus_pkg.sv | 19 +
 rtl/hyperbus_wb_bridge.sv | 149 ++++++++++++++
 tb/tb_hyperbus_wb_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus Wishbone bridge.
//   HBUS_DATA_W  - user-side data width
//   HBUS_SEL_W   - byte-enable / byte-mask width
//   hbus_state_t - bridge FSM state encoding
package hyperbus_pkg;

    localparam int unsigned HBUS_DATA_W = 32;
    localparam int unsigned HBUS_SEL_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RWAIT,
        ST_ACK,
        ST_ERR
    } hbus_state_t;

endpackage

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic 32-bit slave driving the user side of hyperbus_fifo.
// Writes are posted (acked once the FIFO takes the request); reads block
// until read data returns or the read-wait timer expires.
//
// Ports:
//   clk, rstn           - clock, asynchronous active-low reset
//   wb_*                - Wishbone slave (byte address, 4 byte enables)
//   fifo_adr_o          - word address (wb_adr_i >> ADDR_SHIFT)
//   fifo_dat_o          - write data
//   fifo_mask_o         - byte mask, 1 = byte not written
//   fifo_wrq_o/rrq_o    - one-cycle write/read request
//   fifo_tx_ready_i     - FIFO accepts a request this cycle
//   fifo_rx_valid_i/dat - read data return
//   busy_o              - transaction in flight or late responses pending
module hyperbus_wb_bridge
    import hyperbus_pkg::*;
#(
    parameter int unsigned ADDR_SHIFT  = 1,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned MAX_DISCARD = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            wb_adr_i,
    input  logic [HBUS_DATA_W-1:0] wb_dat_i,
    output logic [HBUS_DATA_W-1:0] wb_dat_o,
    input  logic [HBUS_SEL_W-1:0]  wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [31:0]            fifo_adr_o,
    output logic [HBUS_DATA_W-1:0] fifo_dat_o,
    output logic [HBUS_SEL_W-1:0]  fifo_mask_o,
    output logic                   fifo_wrq_o,
    output logic                   fifo_rrq_o,
    input  logic                   fifo_tx_ready_i,
    input  logic                   fifo_rx_valid_i,
    input  logic [HBUS_DATA_W-1:0] fifo_rx_dat_i,
    output logic                   busy_o
);

    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DW     = (MAX_DISCARD > 0) ? $clog2(MAX_DISCARD + 1) : 1;
    localparam int unsigned T_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    hbus_state_t   state, state_n;
    logic [TW-1:0] timer;
    logic [DW-1:0] disc_cnt;
    logic          req;
    logic          capture;
    logic          deliver;
    logic          expire;
    logic          rx_drop;

    assign req = wb_cyc_i & wb_stb_i;

    // Any response arriving while late responses are owed belongs to an
    // abandoned read, even if a new read is already waiting.
    assign rx_drop = fifo_rx_valid_i & (disc_cnt != '0);

    assign wb_ack_o = (state == ST_ACK);
    assign wb_err_o = (state == ST_ERR);
    assign busy_o   = (state != ST_IDLE) | (disc_cnt != '0);

    always_comb begin
        state_n    = state;
        capture    = 1'b0;
        fifo_wrq_o = 1'b0;
        fifo_rrq_o = 1'b0;
        deliver    = 1'b0;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (wb_we_i) begin
                        capture = 1'b1;
                        state_n = (wb_sel_i == '0) ? ST_ACK : ST_WR;
                    end else if (disc_cnt != DW'(MAX_DISCARD)) begin
                        // With the discard tracker full a new read could not be
                        // told apart from a stale response, so hold it off.
                        capture = 1'b1;
                        state_n = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (fifo_tx_ready_i) begin
                    fifo_wrq_o = 1'b1;
                    state_n    = ST_ACK;
                end
            end
            ST_RD: begin
                if (fifo_tx_ready_i) begin
                    fifo_rrq_o = 1'b1;
                    state_n    = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                // Data wins over a timeout expiring in the same cycle.
                if (fifo_rx_valid_i && disc_cnt == '0) begin
                    deliver = 1'b1;
                    state_n = ST_ACK;
                end else if (TIMEOUT != 0 && timer == TW'(T_LAST)) begin
                    expire  = 1'b1;
                    state_n = ST_ERR;
                end
            end
            ST_ACK:  state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            timer       <= '0;
            disc_cnt    <= '0;
            fifo_adr_o  <= '0;
            fifo_dat_o  <= '0;
            fifo_mask_o <= '0;
            wb_dat_o    <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                fifo_adr_o  <= wb_adr_i >> ADDR_SHIFT;
                fifo_dat_o  <= wb_dat_i;
                fifo_mask_o <= ~wb_sel_i;
            end
            if (deliver) begin
                wb_dat_o <= fifo_rx_dat_i;
            end
            if (fifo_rrq_o) begin
                timer <= '0;
            end else if (state == ST_RWAIT) begin
                timer <= timer + TW'(1);
            end
            // Expiry and a discarded response in one cycle cancel out.
            if (expire && !rx_drop) begin
                disc_cnt <= disc_cnt + DW'(1);
            end else if (rx_drop && !expire) begin
                disc_cnt <= disc_cnt - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed self-checking bench for hyperbus_wb_bridge (TIMEOUT=16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Pulse counters tally on the falling edge and are only
// read by the main thread just after a rising edge.
module tb_hyperbus_wb_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] fifo_adr_o;
    logic [31:0] fifo_dat_o;
    logic [3:0]  fifo_mask_o;
    logic        fifo_wrq_o;
    logic        fifo_rrq_o;
    logic        fifo_tx_ready_i;
    logic        fifo_rx_valid_i;
    logic [31:0] fifo_rx_dat_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wrq_cnt = 0, rrq_cnt = 0, ack_cnt = 0, err_cnt = 0, proto_bad = 0;
    int wrq0, rrq0, ack0, err0;

    always #5 clk = ~clk;

    hyperbus_wb_bridge #(
        .ADDR_SHIFT  (1),
        .TIMEOUT     (16),
        .MAX_DISCARD (3)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .wb_adr_i        (wb_adr_i),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_i        (wb_sel_i),
        .wb_we_i         (wb_we_i),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_ack_o        (wb_ack_o),
        .wb_err_o        (wb_err_o),
        .fifo_adr_o      (fifo_adr_o),
        .fifo_dat_o      (fifo_dat_o),
        .fifo_mask_o     (fifo_mask_o),
        .fifo_wrq_o      (fifo_wrq_o),
        .fifo_rrq_o      (fifo_rrq_o),
        .fifo_tx_ready_i (fifo_tx_ready_i),
        .fifo_rx_valid_i (fifo_rx_valid_i),
        .fifo_rx_dat_i   (fifo_rx_dat_i),
        .busy_o          (busy_o)
    );

    always @(negedge clk) begin
        if (fifo_wrq_o) wrq_cnt++;
        if (fifo_rrq_o) rrq_cnt++;
        if (wb_ack_o)   ack_cnt++;
        if (wb_err_o)   err_cnt++;
        if (((fifo_wrq_o || fifo_rrq_o) && !fifo_tx_ready_i) || (fifo_wrq_o && fifo_rrq_o))
            proto_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic snap();
        wrq0 = wrq_cnt;
        rrq0 = rrq_cnt;
        ack0 = ack_cnt;
        err0 = err_cnt;
    endtask

    task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic wb_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // Read with no response; must end in err within a bounded wait.
    task automatic timeout_read(input logic [31:0] adr);
        logic got_err;
        got_err = 1'b0;
        tick();
        wb_req(1'b0, adr, 32'h0, 4'hf);
        for (int i = 0; i < 40; i++) begin
            tick();
            half();
            if (wb_err_o || wb_ack_o) begin
                got_err = wb_err_o;
                break;
            end
        end
        check("timeout_read_err", 32'(got_err), 32'd1);
        wb_idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn            = 1'b0;
        wb_adr_i        = '0;
        wb_dat_i        = '0;
        wb_sel_i        = '0;
        wb_we_i         = 1'b0;
        wb_cyc_i        = 1'b0;
        wb_stb_i        = 1'b0;
        fifo_tx_ready_i = 1'b1;
        fifo_rx_valid_i = 1'b0;
        fifo_rx_dat_i   = '0;

        // Reset state
        tick(); tick(); half();
        check("rst_ack",  32'(wb_ack_o), 32'd0);
        check("rst_err",  32'(wb_err_o), 32'd0);
        check("rst_wrq",  32'(fifo_wrq_o), 32'd0);
        check("rst_rrq",  32'(fifo_rrq_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_adr",  fifo_adr_o, 32'h0);
        check("rst_mask", 32'(fifo_mask_o), 32'h0);
        check("rst_dato", wb_dat_o, 32'h0);
        rstn = 1'b1;

        // 1: full-sel write, FIFO ready
        tick(); snap();
        wb_req(1'b1, 32'h100, 32'hdeadbeef, 4'hf);
        tick(); half();
        check("t1_wrq",  32'(fifo_wrq_o), 32'd1);
        check("t1_adr",  fifo_adr_o, 32'h80);
        check("t1_mask", 32'(fifo_mask_o), 32'h0);
        check("t1_dat",  fifo_dat_o, 32'hdeadbeef);
        check("t1_ack_early", 32'(wb_ack_o), 32'd0);
        tick(); half();
        check("t1_ack",  32'(wb_ack_o), 32'd1);
        wb_idle();
        tick();
        check("t1_wrq_cnt", wrq_cnt - wrq0, 32'd1);
        half();
        check("t1_busy", 32'(busy_o), 32'd0);

        // 2: partial write with FIFO not ready for a while
        tick(); snap();
        fifo_tx_ready_i = 1'b0;
        wb_req(1'b1, 32'h200, 32'hcafef00d, 4'b0011);
        repeat (6) tick();
        check("t2_no_wrq", wrq_cnt - wrq0, 32'd0);
        half();
        check("t2_mask", 32'(fifo_mask_o), 32'hc);
        check("t2_busy", 32'(busy_o), 32'd1);
        tick();
        fifo_tx_ready_i = 1'b1;
        half();
        check("t2_wrq", 32'(fifo_wrq_o), 32'd1);
        tick(); half();
        check("t2_ack", 32'(wb_ack_o), 32'd1);
        wb_idle();
        tick();
        check("t2_wrq_cnt", wrq_cnt - wrq0, 32'd1);
        check("t2_ack_cnt", ack_cnt - ack0, 32'd1);

        // 3: read, data 4 cycles after rrq
        tick(); snap();
        wb_req(1'b0, 32'h8, 32'h0, 4'hf);
        tick(); half();
        check("t3_rrq", 32'(fifo_rrq_o), 32'd1);
        check("t3_adr", fifo_adr_o, 32'h4);
        repeat (4) tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h12345678;
        half();
        check("t3_ack_early", 32'(wb_ack_o), 32'd0);
        tick();
        fifo_rx_valid_i = 1'b0;
        fifo_rx_dat_i   = 32'hffffffff;
        half();
        check("t3_ack", 32'(wb_ack_o), 32'd1);
        check("t3_dat", wb_dat_o, 32'h12345678);
        wb_idle();
        tick();
        check("t3_ack_cnt", ack_cnt - ack0, 32'd1);
        check("t3_rrq_cnt", rrq_cnt - rrq0, 32'd1);

        // 4: timeout 16 cycles after rrq, late data discarded, next read ok
        tick(); snap();
        wb_req(1'b0, 32'h10, 32'h0, 4'hf);
        tick(); half();
        check("t4_rrq", 32'(fifo_rrq_o), 32'd1);
        tick();
        repeat (15) tick();
        half();
        check("t4_no_err_early", 32'(wb_err_o), 32'd0);
        tick(); half();
        check("t4_err", 32'(wb_err_o), 32'd1);
        check("t4_no_ack", 32'(wb_ack_o), 32'd0);
        wb_idle();
        tick();
        check("t4_err_cnt", err_cnt - err0, 32'd1);
        half();
        check("t4_busy_pending", 32'(busy_o), 32'd1);
        tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'hbadbad00;
        tick();
        fifo_rx_valid_i = 1'b0;
        half();
        check("t4_busy_cleared", 32'(busy_o), 32'd0);
        check("t4_dat_kept", wb_dat_o, 32'h12345678);
        tick(); snap();
        wb_req(1'b0, 32'h20, 32'h0, 4'hf);
        tick(); tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h0a0b0c0d;
        tick();
        fifo_rx_valid_i = 1'b0;
        half();
        check("t4_ack2", 32'(wb_ack_o), 32'd1);
        check("t4_dat2", wb_dat_o, 32'h0a0b0c0d);
        wb_idle();
        tick();

        // 5: sel==0 write acks without a FIFO request; reset during RWAIT
        snap();
        wb_req(1'b1, 32'h300, 32'h11111111, 4'h0);
        tick(); half();
        check("t5_ack", 32'(wb_ack_o), 32'd1);
        wb_idle();
        tick();
        check("t5_no_wrq", wrq_cnt - wrq0, 32'd0);
        check("t5_no_rrq", rrq_cnt - rrq0, 32'd0);
        check("t5_mask", 32'(fifo_mask_o), 32'hf);
        timeout_read(32'h40);
        tick();
        wb_req(1'b0, 32'h50, 32'h0, 4'hf);
        tick(); tick(); half();
        check("t5_busy_rwait", 32'(busy_o), 32'd1);
        rstn = 1'b0;
        wb_idle();
        #1;
        check("t5_rst_busy", 32'(busy_o), 32'd0);
        check("t5_rst_ack",  32'(wb_ack_o), 32'd0);
        check("t5_rst_err",  32'(wb_err_o), 32'd0);
        check("t5_rst_adr",  fifo_adr_o, 32'h0);
        check("t5_rst_dato", wb_dat_o, 32'h0);
        tick(); tick(); half();
        rstn = 1'b1;
        tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h77777777;
        tick();
        fifo_rx_valid_i = 1'b0;
        half();
        check("t5_idle_rx_dropped", 32'(busy_o), 32'd0);
        check("t5_idle_rx_dat", wb_dat_o, 32'h0);

        // 6: three timeouts fill the discard tracker; fourth read stalls
        timeout_read(32'h10);
        timeout_read(32'h20);
        timeout_read(32'h30);
        half();
        check("t6_busy_full", 32'(busy_o), 32'd1);
        tick(); snap();
        wb_req(1'b0, 32'h40, 32'h0, 4'hf);
        tick(); tick(); tick();
        check("t6_stall_rrq", rrq_cnt - rrq0, 32'd0);
        half();
        check("t6_stall_busy", 32'(busy_o), 32'd1);
        check("t6_stall_adr", fifo_adr_o, 32'h18);
        tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h0;
        tick();
        fifo_rx_valid_i = 1'b0;
        tick(); half();
        check("t6_rrq", 32'(fifo_rrq_o), 32'd1);
        check("t6_adr", fifo_adr_o, 32'h20);
        tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h1;
        tick();
        fifo_rx_dat_i   = 32'h2;
        tick();
        fifo_rx_dat_i   = 32'h55aa55aa;
        half();
        check("t6_no_ack_discard", 32'(wb_ack_o), 32'd0);
        tick();
        fifo_rx_valid_i = 1'b0;
        half();
        check("t6_ack", 32'(wb_ack_o), 32'd1);
        check("t6_dat", wb_dat_o, 32'h55aa55aa);
        wb_idle();
        tick(); half();
        check("t6_busy_done", 32'(busy_o), 32'd0);

        // 7: data arriving in the expiry cycle is delivered, no err
        tick(); snap();
        wb_req(1'b0, 32'h60, 32'h0, 4'hf);
        tick(); tick();
        repeat (15) tick();
        fifo_rx_valid_i = 1'b1;
        fifo_rx_dat_i   = 32'h600df00d;
        half();
        check("t7_no_err_early", 32'(wb_err_o), 32'd0);
        tick();
        fifo_rx_valid_i = 1'b0;
        half();
        check("t7_ack", 32'(wb_ack_o), 32'd1);
        check("t7_no_err", 32'(wb_err_o), 32'd0);
        check("t7_dat", wb_dat_o, 32'h600df00d);
        wb_idle();
        tick();
        check("t7_err_cnt", err_cnt - err0, 32'd0);
        half();
        check("t7_busy", 32'(busy_o), 32'd0);

        tick();
        check("fifo_req_protocol", proto_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
